// File: rtl/subclock_pkg.sv
// Shared types and helpers for the subclock_bank tick generator.
package subclock_pkg;

    typedef enum logic {
        MODE_FREERUN = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        OS_IDLE,
        OS_RUN,
        OS_DONE
    } os_state_e;

    localparam int unsigned MAX_DIV_WIDTH = 64;

    // Half-period in clocks for a given output frequency, never below 1.
    function automatic int unsigned reset_half(input int unsigned clk_hz,
                                               input int unsigned out_hz);
        int unsigned h;
        h = (out_hz == 0) ? 0 : clk_hz / out_hz / 2;
        return (h == 0) ? 1 : h;
    endfunction

    function automatic logic [MAX_DIV_WIDTH-1:0] clamp_half(input logic [MAX_DIV_WIDTH-1:0] x);
        return (x == '0) ? MAX_DIV_WIDTH'(1) : x;
    endfunction

endpackage

// File: rtl/subclock_channel.sv
// One divider channel: half-period counter, tick level, one-shot sequencing
// and a shadow register so reconfiguration only lands on a toggle edge.
module subclock_channel
    import subclock_pkg::*;
#(
    parameter int unsigned          DIV_WIDTH  = 32,
    parameter logic [DIV_WIDTH-1:0] RESET_HALF = DIV_WIDTH'(1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sync,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_half,
    input  logic                 load_oneshot,
    output logic                 pending,
    output logic                 tick,
    output logic                 strobe
);

    os_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 strobe_q, strobe_d;
    logic [DIV_WIDTH-1:0] half_q, half_d;
    mode_e                mode_q, mode_d;
    logic [DIV_WIDTH-1:0] shadow_half_q, shadow_half_d;
    mode_e                shadow_mode_q, shadow_mode_d;
    logic                 pending_q, pending_d;

    logic running;
    logic terminal;
    logic apply;

    // sync overrides everything, so it suppresses a same-cycle terminal count.
    always_comb begin
        running  = enable && (state_q != OS_DONE) && !sync;
        terminal = running && (cnt_q == half_q - DIV_WIDTH'(1));
        apply    = pending_q && (terminal || !enable || (state_q == OS_DONE) || sync);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sync || !enable) begin
            state_d = OS_IDLE;
        end else if (terminal && tick_q && (mode_q == MODE_ONESHOT)) begin
            state_d = OS_DONE;
        end else if (state_q == OS_IDLE) begin
            state_d = OS_RUN;
        end else if ((state_q == OS_DONE) && apply && (shadow_mode_q == MODE_FREERUN)) begin
            state_d = OS_IDLE;
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        tick_d        = tick_q;
        strobe_d      = 1'b0;
        half_d        = half_q;
        mode_d        = mode_q;
        shadow_half_d = shadow_half_q;
        shadow_mode_d = shadow_mode_q;
        pending_d     = pending_q;

        if (!running) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (terminal) begin
            cnt_d    = '0;
            tick_d   = !tick_q;
            strobe_d = !tick_q;
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end

        if (apply) begin
            half_d    = shadow_half_q;
            mode_d    = shadow_mode_q;
            pending_d = 1'b0;
        end

        if (load) begin
            shadow_half_d = DIV_WIDTH'(clamp_half(MAX_DIV_WIDTH'(load_half)));
            shadow_mode_d = load_oneshot ? MODE_ONESHOT : MODE_FREERUN;
            pending_d     = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            strobe_q      <= 1'b0;
            half_q        <= RESET_HALF;
            mode_q        <= MODE_FREERUN;
            shadow_half_q <= RESET_HALF;
            shadow_mode_q <= MODE_FREERUN;
            pending_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            strobe_q      <= strobe_d;
            half_q        <= half_d;
            mode_q        <= mode_d;
            shadow_half_q <= shadow_half_d;
            shadow_mode_q <= shadow_mode_d;
            pending_q     <= pending_d;
        end
    end

    always_comb begin
        pending = pending_q;
        tick    = tick_q;
        strobe  = strobe_q;
    end

endmodule

// File: rtl/subclock_bank.sv
// Bank of independent programmable tick dividers with a shared
// valid/ready configuration port.
module subclock_bank
    import subclock_pkg::*;
#(
    parameter int unsigned CHANNELS          = 4,
    parameter int unsigned DIV_WIDTH         = 32,
    parameter int unsigned CLOCK_FREQUENCY   = 50_000_000,
    parameter int unsigned DEFAULT_FREQUENCY = 1_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 sync,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [3:0]           cfg_channel,
    input  logic [DIV_WIDTH-1:0] cfg_half,
    input  logic                 cfg_oneshot,
    output logic                 cfg_error,
    output logic [CHANNELS-1:0]  tick_out,
    output logic [CHANNELS-1:0]  strobe_out
);

    localparam logic [DIV_WIDTH-1:0] RESET_HALF =
        DIV_WIDTH'(reset_half(CLOCK_FREQUENCY, DEFAULT_FREQUENCY));

    logic                in_range;
    logic [CHANNELS-1:0] chan_sel;
    logic [CHANNELS-1:0] load_sel;
    logic [CHANNELS-1:0] pending;
    logic                cfg_error_q, cfg_error_d;

    // Out-of-range requests are always accepted so the requester never stalls.
    always_comb begin
        chan_sel = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            chan_sel[i] = (cfg_channel == 4'(i));
        end
        in_range    = ({28'd0, cfg_channel} < 32'(CHANNELS));
        cfg_ready   = in_range ? ~|(pending & chan_sel) : 1'b1;
        load_sel    = (cfg_valid && cfg_ready) ? chan_sel : '0;
        cfg_error_d = cfg_valid && !in_range;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_error_q <= 1'b0;
        end else begin
            cfg_error_q <= cfg_error_d;
        end
    end

    assign cfg_error = cfg_error_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        subclock_channel #(
            .DIV_WIDTH  (DIV_WIDTH),
            .RESET_HALF (RESET_HALF)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .enable       (enable[g]),
            .sync         (sync),
            .load         (load_sel[g]),
            .load_half    (cfg_half),
            .load_oneshot (cfg_oneshot),
            .pending      (pending[g]),
            .tick         (tick_out[g]),
            .strobe       (strobe_out[g])
        );
    end

endmodule

// File: tb/tb_subclock_bank.sv
// Directed bench for subclock_bank: a per-cycle vector table for the config
// handshake plus hand sequences for reset defaults, one-shot, sync and reset.
module tb_subclock_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  enable;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_channel;
    logic [31:0] cfg_half;
    logic        cfg_oneshot;
    logic        cfg_error;
    logic [3:0]  tick_out;
    logic [3:0]  strobe_out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned rise_k, fall_k, strobe_k, strobes, other_bad, quiet_bad;

    typedef struct {
        logic [3:0]  en;
        logic        cv;
        logic [3:0]  ch;
        logic [31:0] half;
        logic        os;
        logic        rdy;
        logic [3:0]  tick;
        logic [3:0]  strb;
        logic        err;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    always #5 clock = ~clock;

    subclock_bank #(
        .CHANNELS          (4),
        .DIV_WIDTH         (32),
        .CLOCK_FREQUENCY   (50_000_000),
        .DEFAULT_FREQUENCY (1_000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .sync        (sync),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_channel (cfg_channel),
        .cfg_half    (cfg_half),
        .cfg_oneshot (cfg_oneshot),
        .cfg_error   (cfg_error),
        .tick_out    (tick_out),
        .strobe_out  (strobe_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input logic v, input logic [3:0] ch, input logic [31:0] h, input logic os);
        cfg_valid   = v;
        cfg_channel = ch;
        cfg_half    = h;
        cfg_oneshot = os;
    endtask

    function automatic vec_t mk(input logic [3:0] en, input logic cv, input logic [3:0] ch,
                                input logic [31:0] half, input logic rdy,
                                input logic [3:0] tick, input logic [3:0] strb, input logic err);
        vec_t v;
        v.en = en; v.cv = cv; v.ch = ch; v.half = half; v.os = 1'b0;
        v.rdy = rdy; v.tick = tick; v.strb = strb; v.err = err;
        return v;
    endfunction

    // Ideal free-running square wave k edges after a phase restart.
    function automatic logic sq(input int unsigned k, input int unsigned h);
        return ((k / h) % 2) == 1;
    endfunction

    function automatic logic st(input int unsigned k, input int unsigned h);
        return ((k % h) == 0) && (((k / h) % 2) == 1);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Config handshake, cfg_half=0 and out-of-range rows.
        vecs[0]  = mk(4'b0000, 1, 1, 5, 1, 4'b0000, 4'b0000, 0);
        vecs[1]  = mk(4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[2]  = mk(4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[3]  = mk(4'b0010, 1, 1, 3, 1, 4'b0000, 4'b0000, 0);
        vecs[4]  = mk(4'b0010, 0, 1, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[5]  = mk(4'b0010, 0, 1, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[6]  = mk(4'b0010, 0, 1, 0, 0, 4'b0010, 4'b0010, 0);
        vecs[7]  = mk(4'b0010, 0, 1, 0, 1, 4'b0010, 4'b0000, 0);
        vecs[8]  = mk(4'b0010, 0, 1, 0, 1, 4'b0010, 4'b0000, 0);
        vecs[9]  = mk(4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[10] = mk(4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[11] = mk(4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[12] = mk(4'b0010, 0, 1, 0, 1, 4'b0010, 4'b0010, 0);
        vecs[13] = mk(4'b0010, 0, 1, 0, 1, 4'b0010, 4'b0000, 0);
        vecs[14] = mk(4'b0000, 1, 2, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[15] = mk(4'b0000, 0, 2, 0, 0, 4'b0000, 4'b0000, 0);
        vecs[16] = mk(4'b0100, 0, 2, 0, 1, 4'b0100, 4'b0100, 0);
        vecs[17] = mk(4'b0100, 0, 2, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[18] = mk(4'b0100, 0, 2, 0, 1, 4'b0100, 4'b0100, 0);
        vecs[19] = mk(4'b0100, 0, 2, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[20] = mk(4'b0000, 1, 9, 7, 1, 4'b0000, 4'b0000, 1);
        vecs[21] = mk(4'b0000, 0, 9, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[22] = mk(4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[23] = mk(4'b0010, 0, 1, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[24] = mk(4'b0010, 0, 1, 0, 1, 4'b0010, 4'b0010, 0);
        vecs[25] = mk(4'b0000, 0, 1, 0, 1, 4'b0000, 4'b0000, 0);

        reset  = 1'b1;
        enable = 4'b0000;
        sync   = 1'b0;
        set_cfg(0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;

        check("rst_tick", 32'(tick_out), 32'h0);
        check("rst_strobe", 32'(strobe_out), 32'h0);
        check("rst_error", 32'(cfg_error), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);

        // Default rate on ch0: 50 MHz / 1 kHz / 2 = 25000 clocks per half.
        enable = 4'b0001;
        rise_k = 0; fall_k = 0; strobe_k = 0; strobes = 0; other_bad = 0;
        for (int unsigned k = 1; k <= 50000; k++) begin
            step();
            if (tick_out[0] && rise_k == 0) rise_k = k;
            if (!tick_out[0] && rise_k != 0 && fall_k == 0) fall_k = k;
            if (strobe_out[0]) begin
                strobes++;
                if (strobe_k == 0) strobe_k = k;
            end
            if (tick_out[3:1] != 3'b000 || strobe_out[3:1] != 3'b000) other_bad++;
        end
        check("ch0_first_rise", rise_k, 25000);
        check("ch0_fall", fall_k, 50000);
        check("ch0_strobe_count", strobes, 1);
        check("ch0_strobe_edge", strobe_k, 25000);
        check("ch1_3_idle", other_bad, 0);
        enable = 4'b0000;
        step();
        check("ch0_disable_tick", 32'(tick_out), 32'h0);

        for (int i = 0; i < NV; i++) begin
            enable = vecs[i].en;
            set_cfg(vecs[i].cv, vecs[i].ch, vecs[i].half, vecs[i].os);
            #1;
            check($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(vecs[i].rdy));
            step();
            check($sformatf("vec%0d_tick", i), 32'(tick_out), 32'(vecs[i].tick));
            check($sformatf("vec%0d_strobe", i), 32'(strobe_out), 32'(vecs[i].strb));
            check($sformatf("vec%0d_error", i), 32'(cfg_error), 32'(vecs[i].err));
        end
        set_cfg(0, 0, 0, 0);

        // One-shot on ch3 with H=4, then re-arm by cycling enable.
        set_cfg(1, 3, 4, 1);
        step();
        set_cfg(0, 3, 0, 0);
        step();
        for (int pass = 0; pass < 2; pass++) begin
            enable = 4'b1000;
            for (int unsigned k = 1; k <= 16; k++) begin
                step();
                check($sformatf("os%0d_tick_k%0d", pass, k), 32'(tick_out),
                      (k >= 4 && k <= 7) ? 32'h8 : 32'h0);
                check($sformatf("os%0d_strobe_k%0d", pass, k), 32'(strobe_out),
                      (k == 4) ? 32'h8 : 32'h0);
            end
            enable = 4'b0000;
            step();
            check($sformatf("os%0d_off_tick", pass), 32'(tick_out), 32'h0);
        end

        // ch0=2, ch1=3 (kept from the table), ch2=7; sync lands on a ch0 rise.
        set_cfg(1, 0, 2, 0);
        step();
        set_cfg(1, 2, 7, 0);
        step();
        set_cfg(0, 0, 0, 0);
        step();
        enable = 4'b0111;
        for (int k = 0; k < 5; k++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_tick", 32'(tick_out), 32'h0);
        check("sync_strobe", 32'(strobe_out), 32'h0);
        for (int unsigned k = 1; k <= 16; k++) begin
            step();
            check($sformatf("post_sync_tick_k%0d", k), 32'(tick_out),
                  32'({1'b0, sq(k, 7), sq(k, 3), sq(k, 2)}));
            check($sformatf("post_sync_strobe_k%0d", k), 32'(strobe_out),
                  32'({1'b0, st(k, 7), st(k, 3), st(k, 2)}));
        end

        // Reset with a pending request on ch2.
        set_cfg(1, 2, 9, 0);
        step();
        set_cfg(0, 2, 0, 0);
        #1;
        check("pending_before_reset", 32'(cfg_ready), 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_tick", 32'(tick_out), 32'h0);
        check("midrst_strobe", 32'(strobe_out), 32'h0);
        check("midrst_error", 32'(cfg_error), 32'h0);
        check("midrst_ready", 32'(cfg_ready), 32'h1);
        enable = 4'b0100;
        quiet_bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (tick_out != 4'b0000 || strobe_out != 4'b0000) quiet_bad++;
        end
        check("post_reset_ch2_quiet", quiet_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
